// File: rtl/fix_session_arbiter.sv
// Message-granular round-robin arbiter merging four session FIFOs onto one
// downstream serializer read port; a grant is held from header through last body word.
module fix_session_arbiter #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned LEN_W = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      empty_i,
  input  logic [N_SRC*64-1:0]   data_i,
  output logic [N_SRC-1:0]      readreq_o,
  input  logic                  rd_req_i,
  output logic                  empty_o,
  output logic [63:0]           data_o,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned LEN_LSB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   data_sel;
  logic [CNT_W-1:0]    hdr_cnt;
  logic                found;
  logic [ID_W-1:0]     sel;
  logic [ID_W-1:0]     idx;
  logic                pop;

  assign data_sel = data_i[DATA_W*32'(grant_q) +: DATA_W];
  // Body word count: ceil(len/8), computed wide enough that len=32767 yields 4096.
  assign hdr_cnt  = (CNT_W'(data_sel[LEN_LSB +: LEN_W]) + CNT_W'(7)) >> 3;

  // Round-robin search starting one past the last granted source.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      idx = ptr_q + ID_W'(i);
      if (!found && !empty_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state and read-path muxing.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    empty_o   = 1'b1;
    data_o    = '0;
    readreq_o = '0;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          ptr_d   = sel;
          state_d = HDR;
        end
      end
      HDR, BODY: begin
        empty_o            = empty_i[grant_q];
        data_o             = data_sel;
        pop                = rd_req_i & ~empty_i[grant_q];
        readreq_o[grant_q] = pop;
        if (pop) begin
          if (state_q == HDR) begin
            if (hdr_cnt == '0) begin
              state_d = IDLE;
            end else begin
              cnt_d   = hdr_cnt;
              state_d = BODY;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= ID_W'(N_SRC - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_fix_session_arbiter.sv
// Directed bench for fix_session_arbiter: a per-source FIFO model feeds the DUT
// and each scenario task checks grants, pop counts and stall behaviour.
module tb_fix_session_arbiter;

  localparam int unsigned DEPTH = 4608;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   empty_i;
  logic [255:0] data_i;
  logic [3:0]   readreq_o;
  logic         rd_req_i;
  logic         empty_o;
  logic [63:0]  data_o;
  logic [1:0]   grant_o;
  logic         busy_o;

  fix_session_arbiter #(.N_SRC(4), .LEN_W(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .empty_i   (empty_i),
    .data_i    (data_i),
    .readreq_o (readreq_o),
    .rd_req_i  (rd_req_i),
    .empty_o   (empty_o),
    .data_o    (data_o),
    .grant_o   (grant_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [4][DEPTH];
  int head [4];
  int tail [4];
  int tests = 0;
  int fails = 0;
  int pop_cnt [4];
  int viol_onehot = 0;
  int viol_empty_pop = 0;
  int path_bad = 0;
  int busy_cycles;
  int glog [$];
  int gap_min, gap_max, gap_cur;
  logic prev_busy;
  logic seen_grant;

  function automatic logic [63:0] hdr(int len, int id);
    return (64'(len) << 4) | 64'(id & 3);
  endfunction

  function automatic logic [63:0] body(int k, int i);
    return {16'hB0D0, 16'(k), 32'(i)};
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < 4; k++) begin
      if (head[k] < tail[k]) begin
        empty_i[k]         = 1'b0;
        data_i[64*k +: 64] = mem[k][head[k]];
      end else begin
        empty_i[k]         = 1'b1;
        data_i[64*k +: 64] = '0;
      end
    end
  endtask

  task automatic push(int k, logic [63:0] w);
    mem[k][tail[k]] = w;
    tail[k]++;
    drive_inputs();
  endtask

  task automatic flush();
    for (int k = 0; k < 4; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    drive_inputs();
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 4; k++) pop_cnt[k] = 0;
    busy_cycles = 0;
    glog.delete();
    gap_min    = 1000;
    gap_max    = 0;
    gap_cur    = 0;
    seen_grant = 1'b0;
    prev_busy  = busy_o;
  endtask

  // Records protocol statistics for the cycle just settled.
  task automatic sample();
    int g;
    logic exp_e;
    logic [63:0] exp_d;
    logic [3:0] exp_rr;
    if ($countones(readreq_o) > 1) viol_onehot++;
    if (readreq_o != 4'b0 && empty_o) viol_empty_pop++;
    if (busy_o) begin
      g      = int'(grant_o);
      exp_e  = (head[g] >= tail[g]);
      exp_d  = exp_e ? 64'd0 : mem[g][head[g]];
      exp_rr = (rd_req_i && !exp_e) ? 4'(1 << g) : 4'b0;
      if (empty_o !== exp_e || data_o !== exp_d || readreq_o !== exp_rr) path_bad++;
      busy_cycles++;
      if (!prev_busy) begin
        glog.push_back(g);
        if (seen_grant) begin
          if (gap_cur < gap_min) gap_min = gap_cur;
          if (gap_cur > gap_max) gap_max = gap_cur;
        end
        seen_grant = 1'b1;
        gap_cur    = 0;
      end
    end else begin
      if (empty_o !== 1'b1 || data_o !== 64'd0 || readreq_o !== 4'b0) path_bad++;
      gap_cur++;
    end
    prev_busy = busy_o;
  endtask

  task automatic step();
    logic [3:0] rr;
    #1;
    rr = readreq_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (rr[k]) begin
        head[k]++;
        pop_cnt[k]++;
      end
    end
    drive_inputs();
    #1;
    sample();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    rd_req_i = 1'b0;
    flush();
    #1;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    tests++; if (grant_o !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d want 0", grant_o); end
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    tests++; if (data_o !== 64'd0) begin fails++; $display("FAIL reset_data: got %h want 0", data_o); end
    push(2, hdr(8, 2));
    rd_req_i = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy_o !== 1'b0 || grant_o !== 2'd0 || readreq_o !== 4'b0) begin
      fails++; $display("FAIL reset_hold: busy=%b grant=%0d rr=%b want 0/0/0", busy_o, grant_o, readreq_o); end
    flush();
    rd_req_i = 1'b0;
    rst = 1'b0;
    #1;
    tests++; if (busy_o !== 1'b0 || empty_o !== 1'b1 || readreq_o !== 4'b0) begin
      fails++; $display("FAIL reset_release: busy=%b empty=%b rr=%b want 0/1/0", busy_o, empty_o, readreq_o); end
    prev_busy = busy_o;
  endtask

  task automatic test_single_source();
    clear_stats();
    rd_req_i = 1'b1;
    push(2, hdr(20, 2));
    for (int i = 0; i < 3; i++) push(2, body(2, i));
    for (int i = 0; i < 20 && !(seen_grant && !busy_o); i++) step();
    tests++; if (!(seen_grant && !busy_o)) begin fails++; $display("FAIL single_timeout: busy=%b want 0 after grant", busy_o); end
    tests++; if (glog.size() != 1 || glog[0] != 2) begin fails++; $display("FAIL single_grant: got %0d grants first=%0d want 1 grant of 2", glog.size(), glog.size() > 0 ? glog[0] : -1); end
    tests++; if (pop_cnt[2] != 4) begin fails++; $display("FAIL single_pops: got %0d want 4", pop_cnt[2]); end
    tests++; if (busy_cycles != 4) begin fails++; $display("FAIL single_consecutive: busy cycles %0d want 4", busy_cycles); end
  endtask

  task automatic test_contention();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int exp_pops [4]  = '{4, 2, 2, 2};
    rst = 1'b1; #2; rst = 1'b0; #1;
    clear_stats();
    rd_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(k, hdr(8, k));
      push(k, body(k, 0));
    end
    push(0, hdr(8, 0));
    push(0, body(0, 1));
    for (int i = 0; i < 60 && !(glog.size() == 5 && !busy_o); i++) step();
    tests++; if (glog.size() != 5) begin fails++; $display("FAIL cont_count: got %0d grants want 5", glog.size()); end
    for (int i = 0; i < 5 && i < glog.size(); i++) begin
      tests++; if (glog[i] != exp_order[i]) begin fails++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, glog[i], exp_order[i]); end
    end
    for (int k = 0; k < 4; k++) begin
      tests++; if (pop_cnt[k] != exp_pops[k]) begin fails++; $display("FAIL cont_pops[%0d]: got %0d want %0d", k, pop_cnt[k], exp_pops[k]); end
    end
    tests++; if (gap_min != 1 || gap_max != 1) begin fails++; $display("FAIL cont_bubble: gap min %0d max %0d want 1/1", gap_min, gap_max); end
  endtask

  task automatic test_zero_len();
    clear_stats();
    rd_req_i = 1'b1;
    push(1, hdr(0, 1));
    for (int i = 0; i < 10 && !(seen_grant && !busy_o); i++) step();
    tests++; if (glog.size() != 1 || glog[0] != 1) begin fails++; $display("FAIL zero_grant: got %0d grants want one of 1", glog.size()); end
    tests++; if (pop_cnt[1] != 1) begin fails++; $display("FAIL zero_pops: got %0d want 1", pop_cnt[1]); end
    tests++; if (busy_cycles != 1 || busy_o !== 1'b0) begin fails++; $display("FAIL zero_busy: cycles %0d busy=%b want 1/0", busy_cycles, busy_o); end
  endtask

  task automatic test_rd_req_gating();
    clear_stats();
    rd_req_i = 1'b0;
    push(3, hdr(8, 3));
    push(3, body(3, 0));
    for (int i = 0; i < 6; i++) step();
    tests++; if (busy_o !== 1'b1 || grant_o !== 2'd3 || pop_cnt[3] != 0) begin
      fails++; $display("FAIL gate_hold: busy=%b grant=%0d pops=%0d want 1/3/0", busy_o, grant_o, pop_cnt[3]); end
    rd_req_i = 1'b1;
    for (int i = 0; i < 10 && busy_o; i++) step();
    tests++; if (pop_cnt[3] != 2 || busy_o !== 1'b0) begin fails++; $display("FAIL gate_done: pops=%0d busy=%b want 2/0", pop_cnt[3], busy_o); end
  endtask

  task automatic test_starvation();
    clear_stats();
    rd_req_i = 1'b1;
    push(0, hdr(24, 0));
    push(0, body(0, 0));
    push(0, body(0, 1));
    for (int i = 0; i < 5 && !busy_o; i++) step();
    push(3, hdr(8, 3));
    push(3, body(3, 0));
    for (int i = 0; i < 10 && pop_cnt[0] < 3; i++) step();
    for (int i = 0; i < 8; i++) step();
    tests++; if (grant_o !== 2'd0 || empty_o !== 1'b1 || busy_o !== 1'b1) begin
      fails++; $display("FAIL starve_hold: grant=%0d empty=%b busy=%b want 0/1/1", grant_o, empty_o, busy_o); end
    tests++; if (pop_cnt[0] != 3 || pop_cnt[3] != 0) begin fails++; $display("FAIL starve_pops: src0 %0d src3 %0d want 3/0", pop_cnt[0], pop_cnt[3]); end
    push(0, body(0, 2));
    for (int i = 0; i < 5 && busy_o; i++) step();
    tests++; if (pop_cnt[0] != 4 || busy_o !== 1'b0) begin fails++; $display("FAIL starve_finish: pops %0d busy=%b want 4/0", pop_cnt[0], busy_o); end
    for (int i = 0; i < 5 && !busy_o; i++) step();
    tests++; if (grant_o !== 2'd3 || busy_o !== 1'b1) begin fails++; $display("FAIL starve_next: grant=%0d busy=%b want 3/1", grant_o, busy_o); end
    for (int i = 0; i < 10 && busy_o; i++) step();
  endtask

  task automatic test_reset_mid_body();
    clear_stats();
    rd_req_i = 1'b1;
    push(2, hdr(24, 2));
    for (int i = 0; i < 3; i++) push(2, body(2, i));
    for (int i = 0; i < 10 && pop_cnt[2] < 2; i++) step();
    tests++; if (busy_o !== 1'b1 || grant_o !== 2'd2 || data_o !== body(2, 1)) begin
      fails++; $display("FAIL rstmid_setup: busy=%b grant=%0d data=%h", busy_o, grant_o, data_o); end
    rst = 1'b1;
    #1;
    tests++; if (busy_o !== 1'b0 || grant_o !== 2'd0 || empty_o !== 1'b1 || data_o !== 64'd0 || readreq_o !== 4'b0) begin
      fails++; $display("FAIL rstmid_async: busy=%b grant=%0d empty=%b data=%h rr=%b want 0/0/1/0/0", busy_o, grant_o, empty_o, data_o, readreq_o); end
    flush();
    push(3, hdr(8, 3));
    push(3, body(3, 0));
    push(1, hdr(8, 1));
    push(1, body(1, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    clear_stats();
    for (int i = 0; i < 30 && !(glog.size() == 2 && !busy_o); i++) step();
    tests++; if (glog.size() != 2 || glog[0] != 1 || glog[1] != 3) begin
      fails++; $display("FAIL rstmid_regrant: got %0d grants first=%0d want 1 then 3", glog.size(), glog.size() > 0 ? glog[0] : -1); end
  endtask

  task automatic test_max_len();
    flush();
    clear_stats();
    rd_req_i = 1'b1;
    mem[0][0] = hdr(32767, 0);
    for (int i = 1; i <= 4096; i++) mem[0][i] = body(0, i);
    tail[0] = 4097;
    drive_inputs();
    for (int i = 0; i < 4300 && !(seen_grant && !busy_o); i++) step();
    tests++; if (pop_cnt[0] != 4097 || busy_o !== 1'b0) begin fails++; $display("FAIL maxlen_pops: got %0d busy=%b want 4097/0", pop_cnt[0], busy_o); end
    tests++; if (busy_cycles != 4097) begin fails++; $display("FAIL maxlen_cycles: got %0d want 4097", busy_cycles); end
  endtask

  task automatic test_overlap();
    tests++; if (viol_onehot != 0) begin fails++; $display("FAIL onehot: %0d cycles with multiple pops, want 0", viol_onehot); end
    tests++; if (viol_empty_pop != 0) begin fails++; $display("FAIL pop_while_empty: %0d cycles, want 0", viol_empty_pop); end
    tests++; if (path_bad != 0) begin fails++; $display("FAIL read_path: %0d cycles off-model, want 0", path_bad); end
  endtask

  initial begin
    empty_i  = 4'hF;
    data_i   = '0;
    rd_req_i = 1'b0;
    rst      = 1'b1;
    test_reset();
    test_single_source();
    test_contention();
    test_zero_len();
    test_rd_req_gating();
    test_starvation();
    test_reset_mid_body();
    test_max_len();
    test_overlap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fix_session_arbiter.md
FIX_SESSION_ARBITER -- requirements
Module: fix_session_arbiter

Interface
REQ-001 Parameter: N_SRC, 4, number of session FIFOs; fixed at 4, matching the 2-bit id.
REQ-002 Parameter: LEN_W, 15, width of the header length field, data[18:4], in bytes.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 empty_i  input  4  per-source FIFO empty flags; bit k belongs to source k.
REQ-006 data_i  input  256  per-source FIFO read data; source k on bits [64k+63:64k].
REQ-007 readreq_o  output  4  per-source FIFO pop strobes; at most one bit high per cycle.
REQ-008 rd_req_i  input  1  pop request from the downstream byte serializer.
REQ-009 empty_o  output  1  merged empty flag presented to the serializer.
REQ-010 data_o  output  64  merged read data presented to the serializer.
REQ-011 grant_o  output  2  index of the source currently holding the path.
REQ-012 busy_o  output  1  high while a message is locked to a source.

Function
REQ-013 The block SHALL give one downstream serializer exclusive, message-granular access to 4 session FIFOs.
REQ-014 A message SHALL be one header word followed by ceil(len/8) body words, where len = header[18:4] (15-bit); the arithmetic is (len+7)>>3 computed at 16 bits with no overflow.
REQ-015 States SHALL be IDLE, HDR and BODY.
- IDLE: busy_o=0, empty_o=1, readreq_o=0.
- If any empty_i bit is 0, the arbiter selects one source, registers grant_o, and moves to HDR on the next edge.
REQ-016 Selection SHALL be round-robin: search starts at (last grant+1) mod 4, and the first source with empty_i=0 wins; after reset the search starts at source 0.
REQ-017 In HDR and BODY: busy_o=1, empty_o=empty_i[grant_o], data_o=data_i word[grant_o] (combinational mux, zero added latency), readreq_o[grant_o]=rd_req_i & ~empty_i[grant_o], all other readreq_o bits 0.
REQ-018 In IDLE, data_o SHALL be 0.
REQ-019 A pop SHALL mean readreq_o[grant_o]=1 in a cycle.
REQ-020 A pop in HDR SHALL latch the word count from data_o[18:4] into a 16-bit counter.
- If the count is 0: go to IDLE.
- Otherwise: go to BODY.
REQ-021 Each pop in BODY SHALL decrement the counter; the pop that takes it from 1 to 0 returns the block to IDLE on the same edge.
REQ-022 rd_req_i while empty_o=1 SHALL be ignored: no pop, no counter change, no state change.
REQ-023 Changes in empty_i of non-granted sources SHALL NOT affect grant_o while busy_o=1; no preemption.
REQ-024 The block SHALL NOT consult the header id field (data[1:0]) for routing; grant_o is the only source index.
REQ-025 A re-grant SHALL need at least one IDLE cycle, so there is one bubble cycle between messages.
REQ-026 If the granted source goes empty mid-message, the block SHALL hold in BODY with empty_o=1 indefinitely until data returns.

Reset
REQ-027 Asserting rst SHALL asynchronously force IDLE, counter=0, grant_o=0, the round-robin pointer to source 3 (so the next search starts at 0), busy_o=0, readreq_o=0, empty_o=1, data_o=0.
REQ-028 Reset asserted mid-message SHALL abandon that message; after release the arbitration restarts from source 0 with no resume.
REQ-029 Outputs SHALL be valid in the first cycle after rst deasserts.

Verification
REQ-030 Single source: only source 2 has data, header len=20, rd_req_i held high -> grant_o=2, exactly 4 pops (1 header + 3 body) on consecutive cycles, then IDLE.
REQ-031 Contention: all 4 sources hold len=8 messages -> grant order 0,1,2,3,0, each message 2 pops, one idle cycle between messages.
REQ-032 Zero length: header len=0 on source 1 -> 1 pop, busy_o falls the next cycle, counter never enters BODY.
REQ-033 Starvation stall: source 0 with len=24 goes empty after 2 body pops while source 3 has data -> grant_o stays 0 and empty_o=1; after refill the 3rd body pop returns IDLE, then source 3 is granted.
REQ-034 Reset mid-BODY: rst pulses during the 2nd body word of source 2 -> all outputs take reset values immediately; the next grant goes to the lowest non-empty source, searching from 0.
REQ-035 Overlap checks: readreq_o is one-hot or zero every cycle; no pop occurs while empty_o=1; len=32767 gives a count of 4096 with no truncation.
